ce_rst_seq: RTL and testbench
=============================

# ce_rst_seq

Parametrised clock-enable and reset sequencer for the ORAO core (and sibling cores) that replaces the fixed 1 MHz divider and hand-coded reset counter in the emu top level. It produces `NUM_CE` independent, runtime-programmable clock-enable channels from `clk_sys` and sequences the system reset through three phases:

- a power-on hold,
- a debounced request hold,
- run.

Selected channels can be frozen during downloads (pause). The block sits in `emu` between `hps_io` status/buttons and the CPU, video and audio clock-enable consumers.

## Interface
Parameters:
- `NUM_CE`, 2: number of clock-enable channels.
- `DIV_W`, 8: width of the per-channel divide and phase fields.
- `POR_CYCLES`, 20000000: power-on hold length in clocks, ≥1.
- `HOLD_CYCLES`, 15: consecutive quiet clocks required before releasing reset, ≥1.
- `PAUSE_MASK`, `'1`: bit i set means `ce_run[i]` is gated by `pause`.

Ports:
- `clk`, in, 1: system clock (`clk_sys`).
- `reset`, in, 1: block reset. One clock; reset is synchronous and active-high. It restarts everything, including the POR hold.
- `rst_req`, in, 1: soft reset request (OR of `RESET`, status reset bits and the user button). Level-sensitive.
- `pause`, in, 1: freeze request (`ioctl_download`).
- `resync`, in, 1: single-cycle pulse that realigns all divider counters.
- `div`, in, `NUM_CE*DIV_W`: channel i period minus 1, in slice `[i*DIV_W +: DIV_W]`.
- `phase`, in, `NUM_CE*DIV_W`: channel i fire position within its period.
- `ce`, out, `NUM_CE`: raw clock enables, one-clock pulses.
- `ce_run`, out, `NUM_CE`: `ce` gated by `sys_reset` and, per `PAUSE_MASK`, by `pause`.
- `sys_reset`, out, 1: system reset to CPU and peripherals.
- `por_done`, out, 1: high once the POR phase has ended.

## Operation
Divider channel i:
- The counter `cnt_i` runs 0..`div_q_i`, then wraps to 0.
- `div_q_i` and `phase_q_i` are sampled from the inputs on reset, on `resync`, and in the cycle `cnt_i` wraps. Mid-period input changes have no effect until then.
- `ce[i]` is registered and equals `(cnt_i == phase_q_i)` from the previous cycle.
- `div`=0 gives period 1. With phase 0, `ce` is high every cycle.
- `phase_q_i` > `div_q_i` means `ce[i]` never fires. This is legal and silent.
- Counters free-run in every sequencer state; `sys_reset` and `pause` do not stop them.
- `resync` forces all `cnt_i` to 0 on the next edge and samples `div`/`phase`. It has priority over wrap.

`ce_run[i]` = `ce[i] & ~sys_reset & ~(pause & PAUSE_MASK[i])`. `ce_run` is combinational from registered signals and `pause`.

Reset sequencer, states POR → HOLD → RUN:
- **POR:** `seq_cnt` increments each cycle. At `POR_CYCLES-1` the block moves to HOLD with `seq_cnt`=0. `rst_req` is ignored in POR.
- **HOLD:** `rst_req` high clears `seq_cnt`. Otherwise, at `HOLD_CYCLES-1` the block moves to RUN; below that, `seq_cnt` increments.
- **RUN:** `rst_req` high moves to HOLD with `seq_cnt`=0. It never returns to POR except via `reset`.

`sys_reset` is registered as `(next_state != RUN)`. `por_done` is registered as `(next_state != POR)`.

## Timing
Reset values:
- `sys_reset`=1, `por_done`=0, `ce`=0, `ce_run`=0.
- All counters 0; state POR.

Cycle numbering: cycle 1 is the first clock with `reset` low.
- POR occupies cycles 1..P, with P = `POR_CYCLES`.
- `por_done` rises in cycle P+1.
- With `rst_req` low throughout, `sys_reset` falls in cycle P+H+1, with H = `HOLD_CYCLES`.

Soft reset:
- `rst_req` asserted in RUN during cycle k gives `sys_reset` high in cycle k+1.
- `sys_reset` stays high until H consecutive low cycles of `rst_req` have elapsed, then falls the cycle after the last one.

Dividers:
- First `ce[i]` is in cycle `phase+1`, measured from reset release or from the cycle after `resync`.
- The period is exactly `div+1` thereafter.

`reset` mid-operation has full effect on the next edge, with all values as listed under Reset values.

## Structure
- Package `ce_rst_pkg` holds the state typedef `seq_state_t` (POR, HOLD, RUN) and the width function for `seq_cnt`, which is `$clog2(max(POR_CYCLES,HOLD_CYCLES))`.
- Sub-module `ce_div`, one channel: counter, sampled `div`/`phase`, registered `ce`. It is instantiated `NUM_CE` times via generate.
- The sequencer FSM lives in `ce_rst_seq`.
- ORAO instance: channel 0 has `div`=49, `phase`=8, giving 1 MHz for the CPU, paused by download. Channel 1 has `PAUSE_MASK` bit clear, for audio.

## Test plan
- **POR/hold release:** `POR_CYCLES`=10, `HOLD_CYCLES`=4, `rst_req`=0 → `por_done` rises in cycle 11; `sys_reset` falls in cycle 15.
- **Hold debounce:** `rst_req` pulses high in cycles 12 and 13 → hold restarts; `sys_reset` falls in cycle 18. A `rst_req` pulse during RUN → `sys_reset` high the next cycle, for exactly 4 cycles after the pulse ends.
- **Divider:** `div`=49, `phase`=8 → `ce` first in cycle 9, then every 50 cycles. `div`=0, `phase`=0 → `ce` every cycle. `phase`=60, `div`=49 → no `ce` over 200 cycles.
- **Runtime reprogram:** change `div` 49→9 at `cnt`=20 → the current 50-cycle period completes, then 10-cycle periods follow. `resync` pulse → next `ce` exactly `phase+1` cycles later.
- **Pause masking:** `PAUSE_MASK`=2'b01, `pause`=1 → `ce_run[0]`=0 and `ce_run[1]` continues; `ce[0]` keeps firing; after `pause` drops, `ce_run[0]` resumes at the original phase.
- **Reset mid-run:** `reset` asserted for one cycle in RUN → all outputs return to reset values the next cycle, and the full POR+HOLD sequence repeats.

Source files
------------

// File: rtl/ce_rst_pkg.sv
// ============================================================================
// ce_rst_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the clock-enable and reset sequencer.
//
// Contents:
//   seq_state_t    - reset sequencer phases (power-on hold, request hold, run)
//   seq_cnt_width  - width of the shared sequencer counter, sized so that it
//                    can count up to the longer of the two hold lengths
// ============================================================================
package ce_rst_pkg;

    // The three phases of the system reset sequence.  Power-on hold is only
    // ever entered through the block reset; the request hold and run phases
    // alternate as the soft reset request comes and goes.
    typedef enum logic [1:0] {
        SEQ_POR  = 2'd0,
        SEQ_HOLD = 2'd1,
        SEQ_RUN  = 2'd2
    } seq_state_t;

    // The counter only ever needs to reach (longest hold - 1), so
    // $clog2(longest) bits are enough.  A floor of one bit keeps the counter
    // a legal vector when both hold lengths are 1.
    function automatic int seq_cnt_width(input int por_cycles, input int hold_cycles);
        int longest;
        longest = (por_cycles > hold_cycles) ? por_cycles : hold_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage : ce_rst_pkg

// File: rtl/ce_div.sv
// ============================================================================
// ce_div
// ----------------------------------------------------------------------------
// One programmable clock-enable channel.  A free-running counter walks
// 0..div_q and wraps; the registered enable fires one clock after the counter
// passes phase_q, giving one pulse per (div_q + 1) clocks.
//
// The divide and phase settings are captured into local copies only at safe
// points (block reset, resync, counter wrap), so software can rewrite them at
// any time without producing a short or stretched period.
//
// Ports:
//   i_clk     in   1      system clock
//   i_reset   in   1      synchronous active-high reset
//   i_resync  in   1      pulse: restart the counter and capture settings
//   i_div     in   DIV_W  period minus one
//   i_phase   in   DIV_W  counter value at which the channel fires
//   o_ce      out  1      one-clock enable pulse
// ============================================================================
module ce_div #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_resync,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_phase,
    output logic             o_ce
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] r_phase_q;
    logic             r_ce;

    logic             w_wrap;
    logic             w_hit;

    // End of period reached: the counter sits on the captured limit.
    assign w_wrap = (r_cnt == r_div_q);

    // A phase beyond the captured limit is never matched, so such a channel
    // simply stays silent.
    assign w_hit  = (r_cnt == r_phase_q);

    // Counter, captured settings and the registered enable.  Resync takes
    // priority over the natural wrap; both restart the count at zero and
    // take fresh copies of the divide and phase inputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_div_q   <= i_div;
            r_phase_q <= i_phase;
            r_ce      <= 1'b0;
        end else begin
            r_ce <= w_hit;
            if (i_resync || w_wrap) begin
                r_cnt     <= '0;
                r_div_q   <= i_div;
                r_phase_q <= i_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_ce = r_ce;

endmodule : ce_div

// File: rtl/ce_rst_seq.sv
// ============================================================================
// ce_rst_seq
// ----------------------------------------------------------------------------
// Clock-enable and system reset sequencer for the ORAO core and its siblings.
// Provides NUM_CE independently programmable clock-enable channels and walks
// the system reset through power-on hold, debounced request hold and run.
//
// Parameters:
//   NUM_CE       number of clock-enable channels
//   DIV_W        width of each channel's divide and phase fields
//   POR_CYCLES   power-on hold length in clocks (>= 1)
//   HOLD_CYCLES  consecutive quiet clocks of i_rst_req before release (>= 1)
//   PAUSE_MASK   bit i set: o_ce_run[i] is frozen while i_pause is high
//
// Ports:
//   i_clk        in   1             system clock (clk_sys)
//   i_reset      in   1             synchronous active-high block reset
//   i_rst_req    in   1             level-sensitive soft reset request
//   i_pause      in   1             freeze request (download in progress)
//   i_resync     in   1             pulse: realign every divider counter
//   i_div        in   NUM_CE*DIV_W  channel i period-1 in [i*DIV_W +: DIV_W]
//   i_phase      in   NUM_CE*DIV_W  channel i fire position in its period
//   o_ce         out  NUM_CE        raw enables, one-clock pulses
//   o_ce_run     out  NUM_CE        enables gated by reset and pause
//   o_sys_reset  out  1             system reset to CPU and peripherals
//   o_por_done   out  1             high once power-on hold has ended
// ============================================================================
module ce_rst_seq
    import ce_rst_pkg::*;
#(
    parameter int                NUM_CE      = 2,
    parameter int                DIV_W       = 8,
    parameter int                POR_CYCLES  = 20000000,
    parameter int                HOLD_CYCLES = 15,
    parameter logic [NUM_CE-1:0] PAUSE_MASK  = '1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_rst_req,
    input  logic                    i_pause,
    input  logic                    i_resync,
    input  logic [NUM_CE*DIV_W-1:0] i_div,
    input  logic [NUM_CE*DIV_W-1:0] i_phase,
    output logic [NUM_CE-1:0]       o_ce,
    output logic [NUM_CE-1:0]       o_ce_run,
    output logic                    o_sys_reset,
    output logic                    o_por_done
);

    localparam int               CNT_W     = seq_cnt_width(POR_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [CNT_W-1:0] r_seq_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_sys_reset;
    logic             r_por_done;
    logic [NUM_CE-1:0] w_ce;
    logic [NUM_CE-1:0] w_pause_gate;

    // ------------------------------------------------------------------------
    // Divider channels.  They free-run regardless of the sequencer state so
    // that enable phases stay aligned across soft resets and pauses.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CE; g++) begin : g_ch
        ce_div #(
            .DIV_W (DIV_W)
        ) u_div (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_resync (i_resync),
            .i_div    (i_div[g*DIV_W +: DIV_W]),
            .i_phase  (i_phase[g*DIV_W +: DIV_W]),
            .o_ce     (w_ce[g])
        );
    end

    // ------------------------------------------------------------------------
    // Sequencer next-state logic.  One counter is shared by the power-on and
    // request holds; every transition between phases clears it so the next
    // phase always starts counting from zero.  A request seen during the hold
    // restarts the quiet-time count, which is what debounces the request.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_seq_cnt;
        unique case (r_state)
            SEQ_POR: begin
                if (r_seq_cnt == POR_LAST) begin
                    w_next_state = SEQ_HOLD;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_seq_cnt + 1'b1;
                end
            end
            SEQ_HOLD: begin
                if (i_rst_req) begin
                    w_next_cnt   = '0;
                end else if (r_seq_cnt == HOLD_LAST) begin
                    w_next_state = SEQ_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_seq_cnt + 1'b1;
                end
            end
            SEQ_RUN: begin
                if (i_rst_req) begin
                    w_next_state = SEQ_HOLD;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = SEQ_POR;
                w_next_cnt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer state register.  The status outputs are registered from the
    // next state, so they change on the same edge as the state itself rather
    // than one clock later.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= SEQ_POR;
            r_seq_cnt   <= '0;
            r_sys_reset <= 1'b1;
            r_por_done  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_seq_cnt   <= w_next_cnt;
            r_sys_reset <= (w_next_state != SEQ_RUN);
            r_por_done  <= (w_next_state != SEQ_POR);
        end
    end

    // ------------------------------------------------------------------------
    // Gated enables.  Only channels selected in PAUSE_MASK are frozen by
    // pause, so e.g. audio can keep ticking while the CPU is held for a
    // download.  The raw enables keep running underneath, which lets a
    // paused channel resume on its original phase.
    // ------------------------------------------------------------------------
    assign w_pause_gate = {NUM_CE{i_pause}} & PAUSE_MASK;
    assign o_ce_run     = w_ce & ~{NUM_CE{r_sys_reset}} & ~w_pause_gate;

    assign o_ce         = w_ce;
    assign o_sys_reset  = r_sys_reset;
    assign o_por_done   = r_por_done;

endmodule : ce_rst_seq

// File: tb/tb_ce_rst_seq.sv
// ============================================================================
// tb_ce_rst_seq
// ----------------------------------------------------------------------------
// Directed bench for ce_rst_seq with short hold lengths (POR 10, HOLD 4) and
// channel 1 exempt from pause.  Edges are counted from the first clock with
// reset low; outputs are sampled on the falling edge after each rising edge,
// so "edge n" values are those registered at rising edge n and seen during
// the following clock.
// ============================================================================
module tb_ce_rst_seq;

    localparam int         NUM_CE      = 2;
    localparam int         DIV_W       = 8;
    localparam int         POR_CYCLES  = 10;
    localparam int         HOLD_CYCLES = 4;
    localparam logic [1:0] PAUSE_MASK  = 2'b01;

    logic        clock = 1'b0;
    logic        reset;
    logic        rstReq;
    logic        pause;
    logic        resync;
    logic [15:0] divBus;
    logic [15:0] phaseBus;
    logic [1:0]  ce;
    logic [1:0]  ceRun;
    logic        sysReset;
    logic        porDone;

    int          checkCount = 0;
    int          passCount  = 0;
    int          edgeNum    = 0;
    int          silentCount;
    logic        expSys;
    logic        pauseNow;

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    ce_rst_seq #(
        .NUM_CE      (NUM_CE),
        .DIV_W       (DIV_W),
        .POR_CYCLES  (POR_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .PAUSE_MASK  (PAUSE_MASK)
    ) dut (
        .i_clk       (clock),
        .i_reset     (reset),
        .i_rst_req   (rstReq),
        .i_pause     (pause),
        .i_resync    (resync),
        .i_div       (divBus),
        .i_phase     (phaseBus),
        .o_ce        (ce),
        .o_ce_run    (ceRun),
        .o_sys_reset (sysReset),
        .o_por_done  (porDone)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at edge %0d: observed %0h, expected %0h",
                     tag, edgeNum, observed, expected);
        end
    endtask

    // Drives the control inputs, then advances one rising edge and parks on
    // the following falling edge where outputs are stable.
    task automatic applyStimulus(input logic rstReqIn, input logic pauseIn,
                                 input logic resyncIn);
        rstReq = rstReqIn;
        pause  = pauseIn;
        resync = resyncIn;
        @(posedge clock);
        edgeNum++;
        @(negedge clock);
    endtask

    // True when a channel first firing at edge 'first' with the given period
    // is expected to pulse at edge n.
    function automatic logic ceFires(input int n, input int first, input int period);
        return (n >= first) && (((n - first) % period) == 0);
    endfunction

    // Checks every output against expected sequencer status and raw enables;
    // the gated enables are derived from those and the current pause level.
    task automatic checkCycle(input logic eSys, input logic ePor, input logic [1:0] eCe);
        logic [1:0] eRun;
        eRun = eCe & ~{2{eSys}} & ~({2{pause}} & PAUSE_MASK);
        checkOutput("sys_reset", 32'(sysReset), 32'(eSys));
        checkOutput("por_done",  32'(porDone),  32'(ePor));
        checkOutput("ce0",       32'(ce[0]),    32'(eCe[0]));
        checkOutput("ce1",       32'(ce[1]),    32'(eCe[1]));
        checkOutput("ce_run0",   32'(ceRun[0]), 32'(eRun[0]));
        checkOutput("ce_run1",   32'(ceRun[1]), 32'(eRun[1]));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " sys_reset"}, 32'(sysReset), 32'd1);
        checkOutput({tag, " por_done"},  32'(porDone),  32'd0);
        checkOutput({tag, " ce"},        32'(ce),       32'd0);
        checkOutput({tag, " ce_run"},    32'(ceRun),    32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        rstReq   = 1'b0;
        pause    = 1'b0;
        resync   = 1'b0;
        // Channel 0: div 49 / phase 8.  Channel 1: div 0 / phase 0.
        divBus   = {8'd0, 8'd49};
        phaseBus = {8'd0, 8'd8};

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkResetValues("power-up");

        // Release from reset with no request: por_done from edge 10,
        // sys_reset released from edge 14.  A one-clock request at edge 40
        // in run holds sys_reset for edges 40..43.  Channel 0 fires at 9
        // and 59; channel 1 fires every edge.
        reset   = 1'b0;
        edgeNum = 0;
        for (int n = 1; n <= 80; n++) begin
            applyStimulus(n == 40, 1'b0, 1'b0);
            expSys = (n < POR_CYCLES + HOLD_CYCLES) || (n >= 40 && n <= 43);
            checkCycle(expSys, n >= POR_CYCLES, {1'b1, ceFires(n, 9, 50)});
        end

        // One-clock block reset while running returns everything to reset.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkResetValues("mid-run reset");

        // Full sequence again with the request high at edges 12 and 13
        // during the hold: quiet count restarts, release from edge 17.
        // At edge 70 channel 0's counter is 20; div changes to 9 there, the
        // 50-clock period completes (pulse at 59, next at 109) and 10-clock
        // periods follow.
        reset   = 1'b0;
        edgeNum = 0;
        for (int n = 1; n <= 135; n++) begin
            if (n == 71) divBus[7:0] = 8'd9;
            applyStimulus(n == 12 || n == 13, 1'b0, 1'b0);
            expSys = (n < 17);
            checkCycle(expSys, n >= POR_CYCLES,
                       {1'b1, (n == 9) || (n == 59) || ceFires(n, 109, 10)});
        end

        // Resync with new settings: channel 0 div 9 / phase 4 fires 5 edges
        // after the resync edge, channel 1 div 3 / phase 2 fires 3 edges
        // after.  Pause spans m = 12..30: ce_run[0] is held off while ce[0]
        // keeps pulsing, ce_run[1] is untouched, and channel 0 resumes on
        // its original phase at m = 35.
        phaseBus[7:0]  = 8'd4;
        divBus[15:8]   = 8'd3;
        phaseBus[15:8] = 8'd2;
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int m = 1; m <= 40; m++) begin
            pauseNow = (m >= 12) && (m <= 30);
            applyStimulus(1'b0, pauseNow, 1'b0);
            checkCycle(1'b0, 1'b1, {ceFires(m, 3, 4), ceFires(m, 5, 10)});
        end

        // Phase beyond the period: channel 0 must stay silent.
        divBus[7:0]   = 8'd49;
        phaseBus[7:0] = 8'd60;
        applyStimulus(1'b0, 1'b0, 1'b1);
        silentCount = 0;
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (ce[0]) silentCount++;
        end
        checkOutput("ce0 silent pulses", 32'(silentCount), 32'd0);
        checkOutput("ce1 after silent run", 32'(ceRun[1]), 32'(ceFires(201, 3, 4)));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_ce_rst_seq
